// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue stage: widths, opcode/funct values,
// ALU operation codes, FSM state encoding and the decoder result bundle.
package alu_issue_ctrl_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int OPRN_WIDTH  = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_MULI  = 6'h1d;

  // R-type funct values double as the ALU operation codes
  localparam logic [OPRN_WIDTH-1:0] ALU_SHL = 6'h01;
  localparam logic [OPRN_WIDTH-1:0] ALU_SHR = 6'h02;
  localparam logic [OPRN_WIDTH-1:0] ALU_ADD = 6'h20;
  localparam logic [OPRN_WIDTH-1:0] ALU_SUB = 6'h22;
  localparam logic [OPRN_WIDTH-1:0] ALU_AND = 6'h24;
  localparam logic [OPRN_WIDTH-1:0] ALU_OR  = 6'h25;
  localparam logic [OPRN_WIDTH-1:0] ALU_NOR = 6'h27;
  localparam logic [OPRN_WIDTH-1:0] ALU_SLT = 6'h2a;
  localparam logic [OPRN_WIDTH-1:0] ALU_MUL = 6'h2c;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  op1;
    logic [DATA_WIDTH-1:0]  op2;
    logic [OPRN_WIDTH-1:0]  oprn;
    logic [RADDR_WIDTH-1:0] dest;
    logic                   legal;
  } decode_t;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational decode of the R/I-type ALU subset: instruction word plus
// register-file read data in, ALU operands/operation/destination/legal out.
module alu_instr_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] rf_data_r1,
  input  logic [DATA_WIDTH-1:0] rf_data_r2,
  output decode_t               dec
);

  logic [5:0]             opcode;
  logic [RADDR_WIDTH-1:0] rt;
  logic [RADDR_WIDTH-1:0] rd;
  logic [4:0]             shamt;
  logic [5:0]             funct;
  logic [15:0]            imm;
  logic [DATA_WIDTH-1:0]  imm_sext;
  logic [DATA_WIDTH-1:0]  imm_zext;

  assign opcode   = instr[31:26];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, imm};

  // rs is consumed through rf_data_r1; the top drives the read addresses itself
  always_comb begin
    dec       = '0;
    dec.oprn  = ALU_ADD;
    dec.op1   = rf_data_r1;
    dec.dest  = rt;
    unique case (opcode)
      OP_RTYPE: begin
        dec.dest = rd;
        case (funct)
          ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT: begin
            dec.legal = 1'b1;
            dec.oprn  = funct;
            dec.op2   = rf_data_r2;
          end
          ALU_SHL, ALU_SHR: begin
            dec.legal = 1'b1;
            dec.oprn  = funct;
            dec.op2   = {{(DATA_WIDTH-5){1'b0}}, shamt};
          end
          default: dec.legal = 1'b0;
        endcase
      end
      OP_ADDI: begin dec.legal = 1'b1; dec.oprn = ALU_ADD; dec.op2 = imm_sext; end
      OP_SLTI: begin dec.legal = 1'b1; dec.oprn = ALU_SLT; dec.op2 = imm_sext; end
      OP_MULI: begin dec.legal = 1'b1; dec.oprn = ALU_MUL; dec.op2 = imm_sext; end
      OP_ANDI: begin dec.legal = 1'b1; dec.oprn = ALU_AND; dec.op2 = imm_zext; end
      OP_ORI:  begin dec.legal = 1'b1; dec.oprn = ALU_OR;  dec.op2 = imm_zext; end
      // lui is a left shift of the zero-extended immediate by 16
      OP_LUI: begin
        dec.legal = 1'b1;
        dec.oprn  = ALU_SHL;
        dec.op1   = imm_zext;
        dec.op2   = DATA_WIDTH'(16);
      end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing stage in front of the ALU: accepts one instruction, decodes
// it, drives the ALU for one cycle and writes the result back (4 cycles each).
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic [RADDR_WIDTH-1:0] rf_addr_r1,
  output logic [RADDR_WIDTH-1:0] rf_addr_r2,
  input  logic [DATA_WIDTH-1:0]  rf_data_r1,
  input  logic [DATA_WIDTH-1:0]  rf_data_r2,
  output logic [DATA_WIDTH-1:0]  alu_op1,
  output logic [DATA_WIDTH-1:0]  alu_op2,
  output logic [OPRN_WIDTH-1:0]  alu_oprn,
  input  logic [DATA_WIDTH-1:0]  alu_out,
  input  logic                   alu_zero,
  output logic                   rf_we,
  output logic [RADDR_WIDTH-1:0] rf_addr_w,
  output logic [DATA_WIDTH-1:0]  rf_data_w,
  output logic                   zero_flag,
  output logic                   illegal
);

  state_t                 state;
  state_t                 state_nxt;
  logic [31:0]            instr_q;
  logic [RADDR_WIDTH-1:0] dest_q;
  logic                   accept;
  decode_t                dec;

  assign accept     = instr_valid & instr_ready;
  assign rf_addr_r1 = instr_q[25:21];
  assign rf_addr_r2 = instr_q[20:16];

  alu_instr_decode u_decode (
    .instr      (instr_q),
    .rf_data_r1 (rf_data_r1),
    .rf_data_r2 (rf_data_r2),
    .dec        (dec)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (accept) state_nxt = ST_DECODE;
      ST_DECODE:    state_nxt = dec.legal ? ST_EXECUTE : ST_IDLE;
      ST_EXECUTE:   state_nxt = ST_WRITEBACK;
      ST_WRITEBACK: state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Ready is registered from the next state so it stays low throughout reset
  // and the ALU-facing registers power up on a defined add operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      instr_ready <= 1'b0;
      instr_q     <= '0;
      dest_q      <= '0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      alu_oprn    <= ALU_ADD;
      rf_we       <= 1'b0;
      rf_addr_w   <= '0;
      rf_data_w   <= '0;
      zero_flag   <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state       <= state_nxt;
      instr_ready <= (state_nxt == ST_IDLE);
      rf_we       <= 1'b0;
      illegal     <= 1'b0;
      unique case (state)
        ST_IDLE: if (accept) instr_q <= instr;
        ST_DECODE: begin
          if (dec.legal) begin
            alu_op1  <= dec.op1;
            alu_op2  <= dec.op2;
            alu_oprn <= dec.oprn;
            dest_q   <= dec.dest;
          end else begin
            illegal  <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          rf_data_w <= alu_out;
          zero_flag <= alu_zero;
          rf_addr_w <= dest_q;
          rf_we     <= (dest_q != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural register file and ALU;
// expected results are hand-computed per instruction.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  rf_addr_r1, rf_addr_r2, rf_addr_w;
  logic [31:0] rf_data_r1, rf_data_r2, rf_data_w;
  logic [31:0] alu_op1, alu_op2, alu_out;
  logic [5:0]  alu_oprn;
  logic        alu_zero, rf_we, zero_flag, illegal;

  logic [31:0] rf [32] = '{default: '0};
  logic        loadEn = 1'b0;
  logic [4:0]  loadAddr = '0;
  logic [31:0] loadData = '0;

  int compareCount  = 0;
  int mismatchCount = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rf_addr_r1  (rf_addr_r1),
    .rf_addr_r2  (rf_addr_r2),
    .rf_data_r1  (rf_data_r1),
    .rf_data_r2  (rf_data_r2),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_oprn    (alu_oprn),
    .alu_out     (alu_out),
    .alu_zero    (alu_zero),
    .rf_we       (rf_we),
    .rf_addr_w   (rf_addr_w),
    .rf_data_w   (rf_data_w),
    .zero_flag   (zero_flag),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Register file model: bench preload port takes priority over DUT writes
  always @(posedge clk) begin
    if (loadEn) rf[loadAddr] <= loadData;
    else if (rf_we && rf_addr_w != 5'd0) rf[rf_addr_w] <= rf_data_w;
  end

  assign rf_data_r1 = (rf_addr_r1 == 5'd0) ? 32'd0 : rf[rf_addr_r1];
  assign rf_data_r2 = (rf_addr_r2 == 5'd0) ? 32'd0 : rf[rf_addr_r2];

  always_comb begin
    alu_out = '0;
    case (alu_oprn)
      6'h20: alu_out = alu_op1 + alu_op2;
      6'h22: alu_out = alu_op1 - alu_op2;
      6'h2c: alu_out = alu_op1 * alu_op2;
      6'h24: alu_out = alu_op1 & alu_op2;
      6'h25: alu_out = alu_op1 | alu_op2;
      6'h27: alu_out = ~(alu_op1 | alu_op2);
      6'h2a: alu_out = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      6'h01: alu_out = alu_op1 << alu_op2;
      6'h02: alu_out = alu_op1 >> alu_op2;
      default: alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic setReg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    loadEn = 1'b1; loadAddr = addr; loadData = data;
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  // Issues one instruction and walks it through DECODE/EXECUTE/WRITEBACK
  task automatic applyStimulus(input string tag, input logic [31:0] word,
                               input logic [5:0] expOprn, input logic expWe,
                               input logic [4:0] expAddr, input logic [31:0] expData,
                               input logic expZero, input logic expIllegal);
    int waitCycles = 0;
    @(negedge clk);
    while (!instr_ready && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!instr_ready) begin
      checkOutput({tag, ".ready_timeout"}, 32'(instr_ready), 32'd1);
      return;
    end
    instr = word; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    checkOutput({tag, ".busy"}, 32'(instr_ready), 32'd0);
    @(negedge clk);
    if (expIllegal) begin
      checkOutput({tag, ".illegal"}, 32'(illegal), 32'd1);
      checkOutput({tag, ".ready"}, 32'(instr_ready), 32'd1);
      checkOutput({tag, ".we"}, 32'(rf_we), 32'd0);
      @(negedge clk);
      checkOutput({tag, ".illegal_end"}, 32'(illegal), 32'd0);
      checkOutput({tag, ".we_after"}, 32'(rf_we), 32'd0);
      checkOutput({tag, ".zero_kept"}, 32'(zero_flag), 32'(expZero));
    end else begin
      checkOutput({tag, ".illegal"}, 32'(illegal), 32'd0);
      checkOutput({tag, ".oprn"}, 32'(alu_oprn), 32'(expOprn));
      checkOutput({tag, ".we_early"}, 32'(rf_we), 32'd0);
      @(negedge clk);
      checkOutput({tag, ".we"}, 32'(rf_we), 32'(expWe));
      checkOutput({tag, ".addr_w"}, 32'(rf_addr_w), 32'(expAddr));
      checkOutput({tag, ".data_w"}, rf_data_w, expData);
      checkOutput({tag, ".zero"}, 32'(zero_flag), 32'(expZero));
      @(negedge clk);
      checkOutput({tag, ".we_end"}, 32'(rf_we), 32'd0);
      checkOutput({tag, ".ready_again"}, 32'(instr_ready), 32'd1);
    end
  endtask

  logic [31:0] seqWords [3];
  int          acceptAt [3];
  int          seqCycle;
  int          seqCount;
  int          weCount;
  logic        readyNow;

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0;

    // Reset state
    @(negedge clk);
    #2;
    checkOutput("rst.ready", 32'(instr_ready), 32'd0);
    checkOutput("rst.oprn", 32'(alu_oprn), 32'h20);
    checkOutput("rst.op1", alu_op1, 32'd0);
    checkOutput("rst.op2", alu_op2, 32'd0);
    checkOutput("rst.we", 32'(rf_we), 32'd0);
    checkOutput("rst.flags", {30'd0, zero_flag, illegal}, 32'd0);
    checkOutput("rst.data_w", rf_data_w, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst.release_ready", 32'(instr_ready), 32'd1);

    setReg(5'd1, 32'd5);
    setReg(5'd2, 32'd7);
    setReg(5'd7, 32'd0);
    setReg(5'd8, 32'd3);

    applyStimulus("add",  {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 6'h20, 1'b1, 5'd3, 32'd12, 1'b0, 1'b0);
    checkOutput("add.rf3", rf[3], 32'd12);
    applyStimulus("addi", {6'h08, 5'd7, 5'd4, 16'hFFFF}, 6'h20, 1'b1, 5'd4, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus("slti", {6'h0a, 5'd7, 5'd6, 16'h0001}, 6'h2a, 1'b1, 5'd6, 32'd1, 1'b0, 1'b0);
    applyStimulus("lui",  {6'h0f, 5'd0, 5'd5, 16'h1234}, 6'h01, 1'b1, 5'd5, 32'h1234_0000, 1'b0, 1'b0);
    applyStimulus("ori",  {6'h0d, 5'd0, 5'd5, 16'hFFFF}, 6'h25, 1'b1, 5'd5, 32'h0000_FFFF, 1'b0, 1'b0);
    applyStimulus("sll",  {6'h00, 5'd8, 5'd0, 5'd2, 5'd4, 6'h01}, 6'h01, 1'b1, 5'd2, 32'd48, 1'b0, 1'b0);
    applyStimulus("sub0", {6'h00, 5'd1, 5'd1, 5'd0, 5'd0, 6'h22}, 6'h22, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus("ill_op", {6'h3f, 26'd0}, 6'h00, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    applyStimulus("ill_fn", {6'h00, 5'd1, 5'd2, 5'd13, 5'd0, 6'h03}, 6'h00, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    checkOutput("ill.rf13", rf[13], 32'd0);

    // VALID held high: back-to-back accepts four cycles apart
    setReg(5'd2, 32'd7);
    seqWords[0] = {6'h00, 5'd1, 5'd2, 5'd9,  5'd0, 6'h20};
    seqWords[1] = {6'h00, 5'd2, 5'd1, 5'd10, 5'd0, 6'h22};
    seqWords[2] = {6'h00, 5'd1, 5'd2, 5'd11, 5'd0, 6'h24};
    seqCycle = 0; seqCount = 0;
    @(negedge clk);
    instr = seqWords[0]; instr_valid = 1'b1;
    while (seqCount < 3 && seqCycle < 40) begin
      readyNow = instr_ready;
      @(negedge clk);
      seqCycle++;
      if (readyNow) begin
        acceptAt[seqCount] = seqCycle;
        seqCount++;
        if (seqCount < 3) instr = seqWords[seqCount];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    checkOutput("seq.count", 32'(seqCount), 32'd3);
    if (seqCount == 3) begin
      checkOutput("seq.gap1", 32'(acceptAt[1] - acceptAt[0]), 32'd4);
      checkOutput("seq.gap2", 32'(acceptAt[2] - acceptAt[1]), 32'd4);
    end
    repeat (6) @(negedge clk);
    checkOutput("seq.rf9", rf[9], 32'd12);
    checkOutput("seq.rf10", rf[10], 32'd2);
    checkOutput("seq.rf11", rf[11], 32'd5);

    // Reset asserted mid-cycle while the instruction sits in EXECUTE
    @(negedge clk);
    checkOutput("midrst.ready_before", 32'(instr_ready), 32'd1);
    instr = {6'h00, 5'd1, 5'd2, 5'd12, 5'd0, 6'h20}; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst.oprn_exec", 32'(alu_oprn), 32'h20);
    checkOutput("midrst.op1_exec", alu_op1, 32'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst.ready", 32'(instr_ready), 32'd0);
    checkOutput("midrst.op1", alu_op1, 32'd0);
    checkOutput("midrst.oprn", 32'(alu_oprn), 32'h20);
    weCount = 0;
    repeat (4) begin
      @(negedge clk);
      if (rf_we) weCount++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rf_we) weCount++;
    end
    checkOutput("midrst.no_we", 32'(weCount), 32'd0);
    checkOutput("midrst.ready_after", 32'(instr_ready), 32'd1);
    checkOutput("midrst.rf12", rf[12], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
